nf_chi_pipe: RTL and testbench

- Elastic, pipelined, 2-share masked chi layer for the Keccak datapath.
- Processes NUM_ROWS independent 5-bit rows per transfer. Each row uses the 20 NullFresh component functions (CF0..CF19); no fresh randomness is consumed.
- All CF outputs are registered before any share compression. This register is the glitch barrier.
- Replaces per-bit component-function instances. Adds row parallelism, a valid/ready handshake and an optional output register.

---
 rtl/nf_chi_pipe.sv | 131 +++++++++++++
 tb/tb_nf_chi_pipe.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nf_chi_pipe.sv
// Elastic 2-share masked Keccak chi layer built from NullFresh component functions.
// Component functions are registered before any share compression; optional output register.
module nf_chi_pipe #(
   parameter int NUM_ROWS = 5,
   parameter bit OUT_REG  = 1'b1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [5*NUM_ROWS-1:0] in_sh1,
   input  logic [5*NUM_ROWS-1:0] in_sh2,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [5*NUM_ROWS-1:0] out_sh1,
   output logic [5*NUM_ROWS-1:0] out_sh2,
   output logic                  busy
);

   localparam int W   = 5 * NUM_ROWS;
   localparam int CFW = 20 * NUM_ROWS;

   logic [CFW-1:0] cf_reg;
   logic [CFW-1:0] cf_next;
   logic           v1_reg;
   logic [W-1:0]   comp_sh1;
   logic [W-1:0]   comp_sh2;
   logic           in_fire;
   logic           s1_adv;

   genvar gi, gj;
   generate
      for (gi = 0; gi < NUM_ROWS; gi++) begin : g_row
         logic a1, b1, c1, d1, e1;
         logic a2, b2, c2, d2, e2;
         assign {e1, d1, c1, b1, a1} = in_sh1[5*gi +: 5];
         assign {e2, d2, c2, b2, a2} = in_sh2[5*gi +: 5];

         assign cf_next[20*gi+0]  = a1 ^ d1 ^ (d1 & e1);
         assign cf_next[20*gi+1]  = d1 & e2;
         assign cf_next[20*gi+2]  = a2 ^ d2 ^ (d2 & e1);
         assign cf_next[20*gi+3]  = d2 & e2;
         assign cf_next[20*gi+4]  = a1 & e1;
         assign cf_next[20*gi+5]  = b1 ^ (a1 & e2);
         assign cf_next[20*gi+6]  = e1 ^ (a2 & e1);
         assign cf_next[20*gi+7]  = b2 ^ e2 ^ (a2 & e2);
         assign cf_next[20*gi+8]  = a1 & b1;
         assign cf_next[20*gi+9]  = a1 ^ c1 ^ (a1 & b2);
         assign cf_next[20*gi+10] = a2 ^ c2 ^ (a2 & b1);
         assign cf_next[20*gi+11] = a2 & b2;
         assign cf_next[20*gi+12] = a1 ^ d1 ^ (b1 & c1);
         assign cf_next[20*gi+13] = a1 ^ b1 ^ (b1 & c2);
         assign cf_next[20*gi+14] = b2 & c1;
         assign cf_next[20*gi+15] = b2 ^ d2 ^ (b2 & c2);
         assign cf_next[20*gi+16] = e1 ^ (c1 & d1);
         assign cf_next[20*gi+17] = c1 ^ (c1 & d2);
         assign cf_next[20*gi+18] = a2 ^ b2 ^ e2 ^ (c2 & d1);
         assign cf_next[20*gi+19] = a2 ^ b2 ^ c2 ^ (c2 & d2);

         // Compression only ever sees registered CFs, never the raw input shares.
         for (gj = 0; gj < 5; gj++) begin : g_bit
            assign comp_sh1[5*gi+gj] = cf_reg[20*gi+4*gj]   ^ cf_reg[20*gi+4*gj+1];
            assign comp_sh2[5*gi+gj] = cf_reg[20*gi+4*gj+2] ^ cf_reg[20*gi+4*gj+3];
         end
      end
   endgenerate

   assign in_ready = ~v1_reg | s1_adv;
   assign in_fire  = in_valid & in_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cf_reg <= '0;
      end else if (in_fire) begin
         cf_reg <= cf_next;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v1_reg <= 1'b0;
      end else if (in_fire) begin
         v1_reg <= 1'b1;
      end else if (s1_adv) begin
         v1_reg <= 1'b0;
      end
   end

   generate
      if (OUT_REG) begin : g_out_reg
         logic [W-1:0] sh1_reg;
         logic [W-1:0] sh2_reg;
         logic         v2_reg;

         assign s1_adv = v1_reg & (~v2_reg | out_ready);

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               sh1_reg <= '0;
               sh2_reg <= '0;
            end else if (s1_adv) begin
               sh1_reg <= comp_sh1;
               sh2_reg <= comp_sh2;
            end
         end

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               v2_reg <= 1'b0;
            end else if (s1_adv) begin
               v2_reg <= 1'b1;
            end else if (out_ready) begin
               v2_reg <= 1'b0;
            end
         end

         assign out_valid = v2_reg;
         assign out_sh1   = sh1_reg;
         assign out_sh2   = sh2_reg;
         assign busy      = v1_reg | v2_reg;
      end else begin : g_out_comb
         // Stage 1 drains straight to the output when downstream accepts.
         assign s1_adv    = v1_reg & out_ready;
         assign out_valid = v1_reg;
         assign out_sh1   = comp_sh1;
         assign out_sh2   = comp_sh2;
         assign busy      = v1_reg;
      end
   endgenerate

endmodule

// File: tb/tb_nf_chi_pipe.sv
// Self-checking bench for nf_chi_pipe: table vectors, scoreboards per instance and
// hand-written sequences for stall, throughput, OUT_REG=0 and asynchronous reset.
`timescale 1ns/1ps
module tb_nf_chi_pipe;
   localparam int W = 125;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic [W-1:0] sh1 = '0;
   logic [W-1:0] sh2 = '0;

   // Instance A: one row, registered output
   logic a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_busy;
   logic [4:0] a_out_sh1, a_out_sh2;
   // Instance B: 25 rows, registered output
   logic b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_busy;
   logic [W-1:0] b_out_sh1, b_out_sh2;
   // Instance C: 5 rows, combinational output
   logic c_in_valid, c_in_ready, c_out_valid, c_out_ready, c_busy;
   logic [24:0] c_out_sh1, c_out_sh2;

   nf_chi_pipe #(.NUM_ROWS(1), .OUT_REG(1'b1)) u_a (
      .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready),
      .in_sh1(sh1[4:0]), .in_sh2(sh2[4:0]), .out_valid(a_out_valid), .out_ready(a_out_ready),
      .out_sh1(a_out_sh1), .out_sh2(a_out_sh2), .busy(a_busy));

   nf_chi_pipe #(.NUM_ROWS(25), .OUT_REG(1'b1)) u_b (
      .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
      .in_sh1(sh1), .in_sh2(sh2), .out_valid(b_out_valid), .out_ready(b_out_ready),
      .out_sh1(b_out_sh1), .out_sh2(b_out_sh2), .busy(b_busy));

   nf_chi_pipe #(.NUM_ROWS(5), .OUT_REG(1'b0)) u_c (
      .clk(clk), .rst_n(rst_n), .in_valid(c_in_valid), .in_ready(c_in_ready),
      .in_sh1(sh1[24:0]), .in_sh2(sh2[24:0]), .out_valid(c_out_valid), .out_ready(c_out_ready),
      .out_sh1(c_out_sh1), .out_sh2(c_out_sh2), .busy(c_busy));

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [W-1:0] chi_model(input logic [W-1:0] x);
      logic [W-1:0] y;
      logic a, b, c, d, e;
      y = '0;
      for (int r = 0; r < 25; r++) begin
         {e, d, c, b, a} = x[5*r +: 5];
         y[5*r+0] = a ^ (d & ~e);
         y[5*r+1] = b ^ (~a & e);
         y[5*r+2] = c ^ (a & ~b);
         y[5*r+3] = d ^ (b & ~c);
         y[5*r+4] = e ^ (c & ~d);
      end
      return y;
   endfunction

   function automatic logic [W-1:0] rand_w();
      logic [127:0] t;
      t = {$urandom, $urandom, $urandom, $urandom};
      return t[W-1:0];
   endfunction

   // Scoreboards: expected unmasked result pushed on input transfer, popped on output transfer
   logic [W-1:0] qa[$];
   logic [W-1:0] qb[$];
   logic [W-1:0] qc[$];
   int b_out_cnt = 0;

   always @(negedge clk) begin
      logic [W-1:0] ev;
      if (rst_n) begin
         if (a_in_valid && a_in_ready) qa.push_back(chi_model(sh1 ^ sh2));
         if (b_in_valid && b_in_ready) qb.push_back(chi_model(sh1 ^ sh2));
         if (c_in_valid && c_in_ready) qc.push_back(chi_model(sh1 ^ sh2));
         if (a_out_valid && a_out_ready) begin
            if (qa.size() == 0) begin
               n_checks++; n_fail++;
               $display("FAIL a_sb: got unexpected output %h required none", a_out_sh1 ^ a_out_sh2);
            end else begin
               ev = qa.pop_front();
               $display("%0t A out y=%h", $time, a_out_sh1 ^ a_out_sh2);
               check("a_sb", W'(a_out_sh1 ^ a_out_sh2), W'(ev[4:0]));
            end
         end
         if (b_out_valid && b_out_ready) begin
            b_out_cnt++;
            if (qb.size() == 0) begin
               n_checks++; n_fail++;
               $display("FAIL b_sb: got unexpected output %h required none", b_out_sh1 ^ b_out_sh2);
            end else begin
               ev = qb.pop_front();
               $display("%0t B out y=%h", $time, b_out_sh1 ^ b_out_sh2);
               check("b_sb", b_out_sh1 ^ b_out_sh2, ev);
            end
         end
         if (c_out_valid && c_out_ready) begin
            if (qc.size() == 0) begin
               n_checks++; n_fail++;
               $display("FAIL c_sb: got unexpected output %h required none", c_out_sh1 ^ c_out_sh2);
            end else begin
               ev = qc.pop_front();
               $display("%0t C out y=%h", $time, c_out_sh1 ^ c_out_sh2);
               check("c_sb", W'(c_out_sh1 ^ c_out_sh2), W'(ev[24:0]));
            end
         end
      end
   end

   typedef struct {
      logic [4:0] x;
      logic [4:0] s1;
      logic [4:0] y;
   } vec_t;
   vec_t tbl[8];

   logic [W-1:0] bx[4];
   logic [W-1:0] bs[4];
   int bk;

   task automatic b_stream(input int target, input int budget);
      int n = 0;
      logic fire;
      while (bk < target && n < budget) begin
         sh1 = bs[bk];
         sh2 = bs[bk] ^ bx[bk];
         b_in_valid = 1'b1;
         @(negedge clk);
         fire = b_in_valid && b_in_ready;
         @(posedge clk); #1;
         if (fire) bk++;
         n++;
      end
      b_in_valid = 1'b0;
   endtask

   task automatic wait_b_empty(input int budget);
      int n = 0;
      while ((qb.size() != 0 || b_busy) && n < budget) begin
         @(posedge clk); #1;
         n++;
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [W-1:0] x, hold1, hold2, ex0, ex1;
      int base;

      tbl[0] = '{5'b01001, 5'b10110, 5'b01100};
      tbl[1] = '{5'b00000, 5'($urandom), 5'b00000};
      tbl[2] = '{5'b11111, 5'($urandom), 5'b11111};
      tbl[3] = '{5'b10000, 5'($urandom), 5'b10010};
      tbl[4] = '{5'b00001, 5'($urandom), 5'b00101};
      tbl[5] = '{5'b00010, 5'($urandom), 5'b01010};
      tbl[6] = '{5'b00100, 5'($urandom), 5'b10100};
      tbl[7] = '{5'b01000, 5'($urandom), 5'b01001};

      a_in_valid = 0; b_in_valid = 0; c_in_valid = 0;
      a_out_ready = 1; b_out_ready = 1; c_out_ready = 1;

      // Reset state
      #1;
      check("rst_a_out_valid", W'(a_out_valid), '0);
      check("rst_b_out_valid", W'(b_out_valid), '0);
      check("rst_b_out_sh1", b_out_sh1, '0);
      check("rst_b_out_sh2", b_out_sh2, '0);
      check("rst_b_busy", W'(b_busy), '0);
      check("rst_c_out_sh1", W'(c_out_sh1), '0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      #1;
      check("rst_a_in_ready", W'(a_in_ready), W'(1));
      check("rst_b_in_ready", W'(b_in_ready), W'(1));
      check("rst_c_in_ready", W'(c_in_ready), W'(1));

      // Table vectors on the single-row instance: latency and value
      foreach (tbl[i]) begin
         @(posedge clk); #1;
         x = rand_w();
         x[4:0] = tbl[i].x;
         sh1 = rand_w();
         sh1[4:0] = tbl[i].s1;
         sh2 = sh1 ^ x;
         a_in_valid = 1'b1;
         check("a_in_ready", W'(a_in_ready), W'(1));
         @(posedge clk); #1;
         a_in_valid = 1'b0;
         check("a_lat1_valid", W'(a_out_valid), '0);
         check("a_lat1_busy", W'(a_busy), W'(1));
         @(posedge clk); #1;
         check("a_lat2_valid", W'(a_out_valid), W'(1));
         check("a_tbl_y", W'(a_out_sh1 ^ a_out_sh2), W'(tbl[i].y));
      end
      @(posedge clk); #1;
      check("a_idle_busy", W'(a_busy), '0);

      // Full throughput on 25 rows: sweep 32 row-0 values x 8 random splits
      base = b_out_cnt;
      for (int k = 0; k < 256; k++) begin
         x = rand_w();
         x[4:0] = 5'(k >> 3);
         sh1 = rand_w();
         sh2 = sh1 ^ x;
         b_in_valid = 1'b1;
         @(negedge clk);
         check("b_stream_in_ready", W'(b_in_ready), W'(1));
         @(posedge clk); #1;
      end
      b_in_valid = 1'b0;
      check("b_throughput", W'(b_out_cnt - base), W'(254));
      wait_b_empty(10);
      check("b_stream_drained", W'(qb.size()), '0);
      check("b_stream_total", W'(b_out_cnt - base), W'(256));

      // Back-pressure: 4 sets with out_ready low, then release
      for (int i = 0; i < 4; i++) begin
         bx[i] = rand_w();
         bs[i] = rand_w();
      end
      bk = 0;
      base = b_out_cnt;
      b_out_ready = 1'b0;
      b_stream(4, 6);
      check("bp_accepted", W'(bk), W'(2));
      check("bp_in_ready", W'(b_in_ready), '0);
      check("bp_out_valid", W'(b_out_valid), W'(1));
      check("bp_y0", b_out_sh1 ^ b_out_sh2, chi_model(bx[0]));
      hold1 = b_out_sh1;
      hold2 = b_out_sh2;
      repeat (3) @(posedge clk);
      #1;
      check("bp_hold_sh1", b_out_sh1, hold1);
      check("bp_hold_sh2", b_out_sh2, hold2);
      check("bp_hold_valid", W'(b_out_valid), W'(1));
      check("bp_no_output", W'(b_out_cnt - base), '0);
      b_out_ready = 1'b1;
      b_stream(4, 20);
      wait_b_empty(10);
      check("bp_all_accepted", W'(bk), W'(4));
      check("bp_all_emerged", W'(b_out_cnt - base), W'(4));
      check("bp_drained", W'(qb.size()), '0);

      // OUT_REG=0: latency 1, in_ready = ~v1 | out_ready across stall and release
      @(posedge clk); #1;
      ex0 = rand_w();
      sh1 = rand_w();
      sh2 = sh1 ^ ex0;
      c_out_ready = 1'b0;
      c_in_valid = 1'b1;
      check("c_ready_empty", W'(c_in_ready), W'(1));
      @(posedge clk); #1;
      check("c_lat1_valid", W'(c_out_valid), W'(1));
      check("c_lat1_y", W'(c_out_sh1 ^ c_out_sh2), W'(chi_model(ex0) & W'(25'h1ffffff)));
      check("c_stall_ready", W'(c_in_ready), '0);
      ex1 = rand_w();
      sh1 = rand_w();
      sh2 = sh1 ^ ex1;
      @(posedge clk); #1;
      check("c_stall_valid", W'(c_out_valid), W'(1));
      check("c_stall_ready2", W'(c_in_ready), '0);
      check("c_stall_y", W'(c_out_sh1 ^ c_out_sh2), W'(chi_model(ex0) & W'(25'h1ffffff)));
      c_out_ready = 1'b1;
      #1;
      check("c_release_ready", W'(c_in_ready), W'(1));
      @(posedge clk); #1;
      c_in_valid = 1'b0;
      check("c_swap_valid", W'(c_out_valid), W'(1));
      check("c_swap_y", W'(c_out_sh1 ^ c_out_sh2), W'(chi_model(ex1) & W'(25'h1ffffff)));
      @(posedge clk); #1;
      check("c_idle_valid", W'(c_out_valid), '0);
      check("c_idle_busy", W'(c_busy), '0);

      // Asynchronous reset with two sets in flight
      for (int i = 0; i < 2; i++) begin
         bx[i] = rand_w();
         bs[i] = rand_w();
      end
      bk = 0;
      b_out_ready = 1'b0;
      b_stream(2, 4);
      check("ar_busy_before", W'(b_busy), W'(1));
      check("ar_valid_before", W'(b_out_valid), W'(1));
      #2;
      rst_n = 1'b0;
      #1;
      check("ar_out_valid", W'(b_out_valid), '0);
      check("ar_out_sh1", b_out_sh1, '0);
      check("ar_out_sh2", b_out_sh2, '0);
      check("ar_busy", W'(b_busy), '0);
      qa.delete();
      qb.delete();
      qc.delete();
      @(posedge clk); #1;
      rst_n = 1'b1;
      b_out_ready = 1'b1;
      @(posedge clk); #1;
      ex0 = rand_w();
      sh1 = rand_w();
      sh2 = sh1 ^ ex0;
      b_in_valid = 1'b1;
      check("ar_in_ready", W'(b_in_ready), W'(1));
      @(posedge clk); #1;
      b_in_valid = 1'b0;
      check("ar_lat1_valid", W'(b_out_valid), '0);
      @(posedge clk); #1;
      check("ar_lat2_valid", W'(b_out_valid), W'(1));
      check("ar_post_y", b_out_sh1 ^ b_out_sh2, chi_model(ex0));
      wait_b_empty(10);

      check("qa_empty", W'(qa.size()), '0);
      check("qb_empty", W'(qb.size()), '0);
      check("qc_empty", W'(qc.size()), '0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
